// File: rtl/rca_pkg.sv
// Shared constants and configuration helpers for the pipelined ripple-carry adder.
package rca_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_SEG    = 8;
    localparam int MAX_STAGES = 16;

    function automatic int stages_of(input int width, input int seg);
        return width / seg;
    endfunction

    function automatic bit cfg_ok(input int width, input int seg);
        if (seg < 1) begin
            return 1'b0;
        end
        return (width % seg == 0) &&
               (width / seg >= 1) &&
               (width / seg <= MAX_STAGES);
    endfunction

    localparam bit DEF_CFG_OK = cfg_ok(DEF_WIDTH, DEF_SEG);

endpackage

// File: rtl/rca_segment.sv
// Combinational SEG-bit ripple adder built from full-adder equations.
module rca_segment #(
    parameter int SEG = 8
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           Cy_in,
    output logic [SEG-1:0] sum,
    output logic           Cy_out
);

    logic [SEG:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = Cy_in;
        for (int i = 0; i < SEG; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        Cy_out = c[SEG];
    end

endmodule

// File: rtl/pipelined_rca.sv
// WIDTH-bit adder split into SEG-bit ripple stages with registered carries.
// Define PIPELINED_RCA_OVF_EN to add the registered signed-overflow output.
module pipelined_rca
    import rca_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SEG   = DEF_SEG
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             Cy_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] sum,
    output logic             Cy_out,
    output logic             out_valid,
`ifdef PIPELINED_RCA_OVF_EN
    output logic             ovf,
`endif
    input  logic             out_ready
);

    localparam int STAGES = stages_of(WIDTH, SEG);
    localparam int LAST   = STAGES - 1;

    generate
        if (!cfg_ok(WIDTH, SEG)) begin : g_bad_cfg
            $error("pipelined_rca: WIDTH must be a multiple of SEG, 1..16 stages");
        end
    endgenerate

    logic             v_q [STAGES];
    logic             c_q [STAGES];
    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] s_q [STAGES];

    logic [WIDTH-1:0] a_src [STAGES];
    logic [WIDTH-1:0] b_src [STAGES];
    logic [WIDTH-1:0] s_src [STAGES];
    logic             c_src [STAGES];

    logic [WIDTH-1:0] a_nx [STAGES];
    logic [WIDTH-1:0] b_nx [STAGES];
    logic [WIDTH-1:0] s_nx [STAGES];

    logic [SEG-1:0]   seg_s [STAGES];
    logic             seg_c [STAGES];

    logic             advance;

    assign advance  = !v_q[LAST] || out_ready;
    assign in_ready = advance;

    // Operands shift down so each stage always adds the low segment;
    // finished segments enter at the top and settle into place by the end.
    always_comb begin
        a_src[0] = a;
        b_src[0] = b;
        c_src[0] = Cy_in;
        s_src[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            a_src[k] = a_q[k-1];
            b_src[k] = b_q[k-1];
            c_src[k] = c_q[k-1];
            s_src[k] = s_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            a_nx[k] = a_src[k] >> SEG;
            b_nx[k] = b_src[k] >> SEG;
            s_nx[k] = (s_src[k] >> SEG) |
                      (WIDTH'(seg_s[k]) << (WIDTH - SEG));
        end
    end

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_seg
            rca_segment #(
                .SEG(SEG)
            ) u_seg (
                .a      (a_src[k][SEG-1:0]),
                .b      (b_src[k][SEG-1:0]),
                .Cy_in  (c_src[k]),
                .sum    (seg_s[k]),
                .Cy_out (seg_c[k])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= 1'b0;
                c_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else if (advance) begin
            v_q[0] <= in_valid;
            for (int k = 1; k < STAGES; k++) begin
                v_q[k] <= v_q[k-1];
            end
            for (int k = 0; k < STAGES; k++) begin
                c_q[k] <= seg_c[k];
                a_q[k] <= a_nx[k];
                b_q[k] <= b_nx[k];
                s_q[k] <= s_nx[k];
            end
        end
    end

    assign sum       = s_q[LAST];
    assign Cy_out    = c_q[LAST];
    assign out_valid = v_q[LAST];

`ifdef PIPELINED_RCA_OVF_EN
    logic cy_msb;
    logic ovf_q;

    // Carry into the MSB recovered from the MSB's own sum equation.
    assign cy_msb = a_src[LAST][SEG-1] ^ b_src[LAST][SEG-1] ^
                    seg_s[LAST][SEG-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (advance) begin
            ovf_q <= cy_msb ^ seg_c[LAST];
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_rca.sv
// Self-checking bench for pipelined_rca: vector table, scoreboard and corner sequences.
module tb_pipelined_rca;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0] a, b, sum;
    logic        cin, cout, in_valid, in_ready, out_valid, out_ready;
    logic [3:0]  a1, b1, s1;
    logic        cin1, co1, iv1, ir1, ov1, or1;
`ifdef PIPELINED_RCA_OVF_EN
    logic        ovf, ovf1;
`endif

    pipelined_rca #(.WIDTH(32), .SEG(8)) u_dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .Cy_in(cin),
        .in_valid(in_valid), .in_ready(in_ready),
        .sum(sum), .Cy_out(cout), .out_valid(out_valid),
`ifdef PIPELINED_RCA_OVF_EN
        .ovf(ovf),
`endif
        .out_ready(out_ready)
    );

    pipelined_rca #(.WIDTH(4), .SEG(4)) u_one (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .Cy_in(cin1),
        .in_valid(iv1), .in_ready(ir1),
        .sum(s1), .Cy_out(co1), .out_valid(ov1),
`ifdef PIPELINED_RCA_OVF_EN
        .ovf(ovf1),
`endif
        .out_ready(or1)
    );

    typedef struct {
        logic [31:0] s;
        logic        c;
        logic        o;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        ci;
        logic [31:0] s;
        logic        c;
    } vec_t;

    exp_t        q[$];
    int          hs_cyc_q[$];
    int          out_cyc_q[$];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    logic [31:0] drv_s;
    logic        drv_c;
    vec_t        tbl[13];

    function automatic logic ovf_of(input logic [31:0] x, y, s);
        return (x[31] == y[31]) && (s[31] != x[31]);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                q.delete();
            end else begin
                if (in_valid && in_ready) begin
                    e.s = drv_s;
                    e.c = drv_c;
                    e.o = ovf_of(a, b, drv_s);
                    q.push_back(e);
                    hs_cyc_q.push_back(cyc);
                end
                if (out_valid && out_ready) begin
                    out_cyc_q.push_back(cyc);
                    if (q.size() == 0) begin
                        chk("unexpected_output", 64'(out_valid), 64'd0);
                    end else begin
                        e = q.pop_front();
                        chk("sb_sum", 64'(sum), 64'(e.s));
                        chk("sb_cy", 64'(cout), 64'(e.c));
`ifdef PIPELINED_RCA_OVF_EN
                        chk("sb_ovf", 64'(ovf), 64'(e.o));
`endif
                    end
                end
            end
        end
    end

    task automatic send(input logic [31:0] x, y, input logic ci,
                        input logic [31:0] es, input logic ec);
        int n;
        a = x; b = y; cin = ci; drv_s = es; drv_c = ec;
        in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 100);
        if (!in_ready) chk("send_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_model(input logic [31:0] x, y, input logic ci);
        logic [32:0] r;
        r = {1'b0, x} + {1'b0, y} + 33'(ci);
        send(x, y, ci, r[31:0], r[32]);
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while (q.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        chk({nm, "_drain"}, 64'(q.size()), 64'd0);
    endtask

    task automatic run1(input string nm, input logic [31:0] x, y,
                        input logic ci, input logic [31:0] es,
                        input logic ec, input logic eo);
        int n;
        send(x, y, ci, es, ec);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 20);
        chk({nm, "_latency"}, 64'(n), 64'd4);
        chk({nm, "_sum"}, 64'(sum), 64'(es));
        chk({nm, "_cy"}, 64'(cout), 64'(ec));
`ifdef PIPELINED_RCA_OVF_EN
        chk({nm, "_ovf"}, 64'(ovf), 64'(eo));
`else
        if (eo === 1'bx) chk({nm, "_eo"}, 64'(eo), 64'd0);
`endif
        @(negedge clk);
        chk({nm, "_single"}, 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  cnt;
        logic        pv;
        logic [31:0] ps;

        tbl[0]  = '{32'h0000000F, 32'h000000F0, 1'b0, 32'h000000FF, 1'b0};
        tbl[1]  = '{32'h00000004, 32'h0000000B, 1'b1, 32'h00000010, 1'b0};
        tbl[2]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1};
        tbl[3]  = '{32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0};
        tbl[4]  = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000001, 1'b0};
        tbl[5]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1};
        tbl[6]  = '{32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0};
        tbl[7]  = '{32'h00FFFFFF, 32'h00000001, 1'b0, 32'h01000000, 1'b0};
        tbl[8]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0};
        tbl[9]  = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1};
        tbl[10] = '{32'h0000FFFF, 32'hFFFF0000, 1'b1, 32'h00000000, 1'b1};
        tbl[11] = '{32'hAAAAAAAA, 32'h55555555, 1'b0, 32'hFFFFFFFF, 1'b0};
        tbl[12] = '{32'h0000FF00, 32'h00000100, 1'b0, 32'h00010000, 1'b0};

        rst = 1'b1; a = '0; b = '0; cin = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1;
        drv_s = '0; drv_c = 1'b0;
        a1 = '0; b1 = '0; cin1 = 1'b0; iv1 = 1'b0; or1 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_sum", 64'(sum), 64'd0);
        chk("rst_cy", 64'(cout), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst1_out_valid", 64'(ov1), 64'd0);
        chk("rst1_sum", 64'(s1), 64'd0);
        @(posedge clk);
        #1;

        run1("t1", 32'hFFFFFFFF, 32'h00000001, 1'b0,
             32'h00000000, 1'b1, 1'b0);

        hs_cyc_q.delete();
        out_cyc_q.delete();
        for (int i = 0; i < 5; i++) begin
            send(tbl[i].a, tbl[i].b, tbl[i].ci, tbl[i].s, tbl[i].c);
        end
        drain("t2");
        chk("t2_count", 64'(out_cyc_q.size()), 64'd5);
        if (out_cyc_q.size() == 5 && hs_cyc_q.size() == 5) begin
            chk("t2_first_lat", 64'(out_cyc_q[0] - hs_cyc_q[0]), 64'd4);
            chk("t2_no_bubble", 64'(out_cyc_q[4] - out_cyc_q[0]), 64'd4);
        end

        for (int i = 5; i < 13; i++) begin
            send(tbl[i].a, tbl[i].b, tbl[i].ci, tbl[i].s, tbl[i].c);
        end
        drain("table");

        out_cyc_q.delete();
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    send(tbl[i].a, tbl[i].b, tbl[i].ci, tbl[i].s, tbl[i].c);
                end
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b0;
                pv = 1'b0;
                ps = '0;
                repeat (6) begin
                    @(negedge clk);
                    if (out_valid) chk("t3_in_ready", 64'(in_ready), 64'd0);
                    if (pv) begin
                        chk("t3_valid_hold", 64'(out_valid), 64'd1);
                        chk("t3_sum_hold", 64'(sum), 64'(ps));
                    end
                    pv = out_valid;
                    ps = sum;
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain("t3");
        chk("t3_count", 64'(out_cyc_q.size()), 64'd8);

        fork
            begin
                repeat (60) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
            begin
                for (int i = 0; i < 24; i++) begin
                    send_model($urandom(), $urandom(), 1'($urandom_range(0, 1)));
                end
            end
        join
        out_ready = 1'b1;
        drain("rand");

        for (int i = 0; i < 3; i++) begin
            send(tbl[i].a, tbl[i].b, tbl[i].ci, tbl[i].s, tbl[i].c);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t4_out_valid", 64'(out_valid), 64'd0);
        chk("t4_sum", 64'(sum), 64'd0);
        chk("t4_cy", 64'(cout), 64'd0);
        chk("t4_in_ready", 64'(in_ready), 64'd1);
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        chk("t4_no_stale", 64'(cnt), 64'd0);
        @(posedge clk);
        #1;
        run1("t4_after", 32'h12345678, 32'h11111111, 1'b0,
             32'h23456789, 1'b0, 1'b0);

        run1("t5_pos", 32'h7FFFFFFF, 32'h00000001, 1'b0,
             32'h80000000, 1'b0, 1'b1);
        run1("t5_neg", 32'hFFFFFFFF, 32'h00000001, 1'b0,
             32'h00000000, 1'b1, 1'b0);

        a1 = 4'b1111; b1 = 4'b1111; cin1 = 1'b0; iv1 = 1'b1;
        @(negedge clk);
        chk("t6_in_ready", 64'(ir1), 64'd1);
        @(posedge clk);
        #1;
        a1 = 4'h7; b1 = 4'h8; cin1 = 1'b1;
        @(negedge clk);
        chk("t6_valid", 64'(ov1), 64'd1);
        chk("t6_sum", 64'(s1), 64'hE);
        chk("t6_cy", 64'(co1), 64'd1);
`ifdef PIPELINED_RCA_OVF_EN
        chk("t6_ovf", 64'(ovf1), 64'd0);
`endif
        @(posedge clk);
        #1;
        iv1 = 1'b0;
        @(negedge clk);
        chk("t6b_valid", 64'(ov1), 64'd1);
        chk("t6b_sum", 64'(s1), 64'h0);
        chk("t6b_cy", 64'(co1), 64'd1);
        @(negedge clk);
        chk("t6_single", 64'(ov1), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
